boot_loader: RTL and testbench
==============================

BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 SHALL have parameter INST_ADDR_WIDTH, default 10, IMEM word-address width.
REQ-002 SHALL have parameter INST_DATA_WIDTH, default 32, instruction word width.
REQ-003 SHALL have parameter START_ADDR, default 0, first IMEM word address written.
REQ-004 SHALL use one clock and an asynchronous, active-high reset (decided).
REQ-005 SHALL have port Clk, input, 1, sole clock; all state updates on rising edge.
REQ-006 SHALL have port Rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port Boot_Req_i, input, 1, single-cycle request to (re)load the program.
REQ-008 SHALL have port Ld_Valid_i, input, 1, load-stream word valid.
REQ-009 SHALL have port Ld_Data_i, input, INST_DATA_WIDTH, load-stream instruction word.
REQ-010 SHALL have port Ld_Last_i, input, 1, marks the final word of the program.
REQ-011 SHALL have port Ld_Ready_o, output, 1, loader accepts a word.
REQ-012 SHALL have port Imem_Wen_o, output, 1, IMEM write strobe.
REQ-013 SHALL have port Imem_Waddr_o, output, INST_ADDR_WIDTH, IMEM write address.
REQ-014 SHALL have port Imem_Wdata_o, output, INST_DATA_WIDTH, IMEM write data.
REQ-015 SHALL have port Cpu_Rst_n_o, output, 1, active-low hold driven to the CPU Rst_n (0 = CPU held).
REQ-016 SHALL have port Cpu_Start_o, output, 1, one-cycle pulse driven to the CPU Start.
REQ-017 SHALL have port Load_Done_o, output, 1, program loaded and CPU released.
REQ-018 SHALL have port Load_Err_o, output, 1, IMEM overflow before Ld_Last_i.
REQ-019 SHALL have port Word_Cnt_o, output, INST_ADDR_WIDTH+1, words accepted in the current load.

Function
REQ-020 SHALL implement an FSM with states IDLE, LOAD, START, RUN, ERR.
REQ-021 SHALL accept a word only when Ld_Valid_i and Ld_Ready_o are both 1 in the same cycle.
REQ-022 SHALL drive Ld_Ready_o = 1 only in LOAD; Ld_Ready_o SHALL NOT depend combinationally on Ld_Valid_i.
REQ-023 IDLE: Cpu_Rst_n_o = 0; Boot_Req_i = 1 -> LOAD with write pointer = START_ADDR and Word_Cnt_o = 0.
REQ-024 LOAD: each accepted word SHALL be registered so that Imem_Wen_o = 1, Imem_Waddr_o = pointer, and Imem_Wdata_o = word in the next cycle, with a latency of exactly 1 cycle.
REQ-025 LOAD: each acceptance SHALL increment the pointer (modulo 2^INST_ADDR_WIDTH) and Word_Cnt_o by 1.
REQ-026 LOAD: an accepted word with Ld_Last_i = 1 SHALL transition to START after that word is written.
REQ-027 LOAD: accepting a word at pointer = all-ones with Ld_Last_i = 0 SHALL write that word and then transition to ERR.
REQ-028 LOAD: an accepted word at pointer = all-ones with Ld_Last_i = 1 SHALL go to START, not ERR.
REQ-029 Boot_Req_i SHALL be ignored in LOAD and START.
REQ-030 START: Cpu_Rst_n_o = 1 and Cpu_Start_o = 1 for exactly one cycle, then -> RUN.
REQ-031 START: Cpu_Rst_n_o SHALL rise in the same cycle Cpu_Start_o is 1 (CPU out of reset when it samples Start).
REQ-032 RUN: Cpu_Rst_n_o = 1 and Load_Done_o = 1; Boot_Req_i = 1 -> LOAD, Cpu_Rst_n_o = 0 and Load_Done_o = 0 the following cycle, counters cleared.
REQ-033 ERR: Load_Err_o = 1, Cpu_Rst_n_o = 0, Ld_Ready_o = 0; Boot_Req_i = 1 -> LOAD with Load_Err_o cleared and counters reset.
REQ-034 Imem_Wen_o SHALL be 0 in every cycle that does not follow an acceptance.
REQ-035 Word_Cnt_o SHALL hold its final value in START, RUN, and ERR until the next LOAD entry.

Reset
REQ-036 On Rst = 1, the block SHALL immediately enter IDLE, asynchronously.
REQ-037 On reset, Ld_Ready_o = 0, Imem_Wen_o = 0, Imem_Waddr_o = 0, Imem_Wdata_o = 0, Cpu_Rst_n_o = 0, Cpu_Start_o = 0, Load_Done_o = 0, Load_Err_o = 0, and Word_Cnt_o = 0.
REQ-038 Reset asserted mid-LOAD SHALL abort the load with no further IMEM writes; a pending registered write SHALL be dropped.

Verification
REQ-039 Bench: Boot_Req, then 4 words 0x11,0x22,0x33,0x44 (last on 0x44) -> IMEM[0..3] written in order; Word_Cnt_o = 4; Cpu_Start_o pulses once; Load_Done_o = 1.
REQ-040 Bench: Ld_Valid_i toggled randomly during LOAD -> no word lost or duplicated; each Imem_Wen_o pulse occurs 1 cycle after its acceptance.
REQ-041 Bench: INST_ADDR_WIDTH = 3, 8 words with no last -> 8 writes, addresses 0..7, then Load_Err_o = 1, Cpu_Rst_n_o = 0, Ld_Ready_o = 0.
REQ-042 Bench: INST_ADDR_WIDTH = 3, Ld_Last_i on the 8th word -> START, not ERR.
REQ-043 Bench: Boot_Req_i in RUN -> Cpu_Rst_n_o = 0 next cycle; reload of 2 words at START_ADDR, Word_Cnt_o = 2, new Start pulse.
REQ-044 Bench: Rst pulsed after 2 accepted words -> all outputs at reset values immediately, no third write, IDLE until Boot_Req_i.

Source files
------------

// File: rtl/boot_loader.sv
// boot_loader: streams a program into instruction memory while holding the CPU
// in reset, then releases the CPU with a one-cycle Start pulse. Overflowing
// the memory before the last word is flagged and the CPU stays held.
module boot_loader #(
   parameter int INST_ADDR_WIDTH = 10,
   parameter int INST_DATA_WIDTH = 32,
   parameter int START_ADDR      = 0
) (
   input  logic                       Clk,
   input  logic                       Rst,
   input  logic                       Boot_Req_i,
   input  logic                       Ld_Valid_i,
   input  logic [INST_DATA_WIDTH-1:0] Ld_Data_i,
   input  logic                       Ld_Last_i,
   output logic                       Ld_Ready_o,
   output logic                       Imem_Wen_o,
   output logic [INST_ADDR_WIDTH-1:0] Imem_Waddr_o,
   output logic [INST_DATA_WIDTH-1:0] Imem_Wdata_o,
   output logic                       Cpu_Rst_n_o,
   output logic                       Cpu_Start_o,
   output logic                       Load_Done_o,
   output logic                       Load_Err_o,
   output logic [INST_ADDR_WIDTH:0]   Word_Cnt_o
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_START = 3'd2,
      S_RUN   = 3'd3,
      S_ERR   = 3'd4
   } state_t;

   localparam logic [INST_ADDR_WIDTH-1:0] C_PTR_START = INST_ADDR_WIDTH'(START_ADDR);
   localparam logic [INST_ADDR_WIDTH-1:0] C_PTR_MAX   = '1;
   localparam logic [INST_ADDR_WIDTH-1:0] C_PTR_ONE   = {{(INST_ADDR_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [INST_ADDR_WIDTH:0]   C_CNT_ONE   = {{INST_ADDR_WIDTH{1'b0}}, 1'b1};

   state_t                       r_state;
   logic [INST_ADDR_WIDTH-1:0]   r_ptr;
   logic [INST_ADDR_WIDTH:0]     r_cnt;
   logic                         r_ready;
   logic                         r_wen;
   logic [INST_ADDR_WIDTH-1:0]   r_waddr;
   logic [INST_DATA_WIDTH-1:0]   r_wdata;
   logic                         r_cpu_rst_n;
   logic                         r_cpu_start;
   logic                         r_done;
   logic                         r_err;

   // Handshake: ready is a register, so acceptance never loops back through valid.
   logic w_accept;
   assign w_accept = Ld_Valid_i & r_ready;

   // Write pipeline: an accepted word appears on the IMEM port exactly one cycle later.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_wen   <= 1'b0;
         r_waddr <= '0;
         r_wdata <= '0;
      end else begin
         r_wen <= w_accept;
         if (w_accept) begin
            r_waddr <= r_ptr;
            r_wdata <= Ld_Data_i;
         end
      end
   end

   // Control FSM with registered outputs; every output is set on the transition into its state.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_state     <= S_IDLE;
         r_ptr       <= C_PTR_START;
         r_cnt       <= '0;
         r_ready     <= 1'b0;
         r_cpu_rst_n <= 1'b0;
         r_cpu_start <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_cpu_start <= 1'b0;
         case (r_state)
            S_IDLE, S_RUN, S_ERR: begin
               if (Boot_Req_i) begin
                  r_state     <= S_LOAD;
                  r_ptr       <= C_PTR_START;
                  r_cnt       <= '0;
                  r_ready     <= 1'b1;
                  r_cpu_rst_n <= 1'b0;
                  r_done      <= 1'b0;
                  r_err       <= 1'b0;
               end
            end
            S_LOAD: begin
               if (w_accept) begin
                  r_ptr <= r_ptr + C_PTR_ONE;
                  r_cnt <= r_cnt + C_CNT_ONE;
                  // Last word wins over overflow: a program that exactly fills memory is valid.
                  if (Ld_Last_i) begin
                     r_state     <= S_START;
                     r_ready     <= 1'b0;
                     r_cpu_rst_n <= 1'b1;
                     r_cpu_start <= 1'b1;
                  end else if (r_ptr == C_PTR_MAX) begin
                     r_state <= S_ERR;
                     r_ready <= 1'b0;
                     r_err   <= 1'b1;
                  end
               end
            end
            S_START: begin
               r_state <= S_RUN;
               r_done  <= 1'b1;
            end
            default: begin
               r_state     <= S_IDLE;
               r_ready     <= 1'b0;
               r_cpu_rst_n <= 1'b0;
               r_done      <= 1'b0;
               r_err       <= 1'b0;
            end
         endcase
      end
   end

   assign Ld_Ready_o   = r_ready;
   assign Imem_Wen_o   = r_wen;
   assign Imem_Waddr_o = r_waddr;
   assign Imem_Wdata_o = r_wdata;
   assign Cpu_Rst_n_o  = r_cpu_rst_n;
   assign Cpu_Start_o  = r_cpu_start;
   assign Load_Done_o  = r_done;
   assign Load_Err_o   = r_err;
   assign Word_Cnt_o   = r_cnt;

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader with a 3-bit IMEM address (8 words) so overflow is reachable.
module tb_boot_loader;
   localparam int AW = 3;
   localparam int DW = 32;
   localparam int DEPTH = 1 << AW;

   logic          clk;
   logic          rst;
   logic          boot;
   logic          valid;
   logic [DW-1:0] data;
   logic          last;
   logic          ld_ready;
   logic          wen;
   logic [AW-1:0] waddr;
   logic [DW-1:0] wdata;
   logic          cpu_rst_n;
   logic          cpu_start;
   logic          done;
   logic          err;
   logic [AW:0]   cnt;

   boot_loader #(.INST_ADDR_WIDTH(AW), .INST_DATA_WIDTH(DW), .START_ADDR(0)) dut (
      .Clk(clk), .Rst(rst), .Boot_Req_i(boot), .Ld_Valid_i(valid), .Ld_Data_i(data),
      .Ld_Last_i(last), .Ld_Ready_o(ld_ready), .Imem_Wen_o(wen), .Imem_Waddr_o(waddr),
      .Imem_Wdata_o(wdata), .Cpu_Rst_n_o(cpu_rst_n), .Cpu_Start_o(cpu_start),
      .Load_Done_o(done), .Load_Err_o(err), .Word_Cnt_o(cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: loader modes as flags, counts as plain integers.
   bit          m_loading = 0, m_starting = 0, m_running = 0, m_error = 0;
   int          m_count = 0, m_next_addr = 0;
   bit          m_wen = 0;
   int          m_waddr = 0;
   logic [DW-1:0] m_wdata = '0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_loading = 0; m_starting = 0; m_running = 0; m_error = 0;
         m_count = 0; m_next_addr = 0;
         m_wen = 0; m_waddr = 0; m_wdata = '0;
      end else begin
         bit took;
         took = m_loading && valid;
         m_wen = took;
         if (took) begin
            m_waddr = m_next_addr;
            m_wdata = data;
         end
         if (m_starting) begin
            m_starting = 0;
            m_running  = 1;
         end else if (m_loading) begin
            if (took) begin
               m_count++;
               if (last) begin
                  m_loading = 0; m_starting = 1;
               end else if (m_next_addr == DEPTH - 1) begin
                  m_loading = 0; m_error = 1;
               end
               m_next_addr = (m_next_addr + 1) % DEPTH;
            end
         end else if (boot) begin
            m_loading = 1; m_running = 0; m_error = 0;
            m_count = 0; m_next_addr = 0;
         end
      end
   end

   // Per-cycle comparison of every output against the model, mid-cycle.
   always @(negedge clk) begin
      chk("ready",  ld_ready,  m_loading);
      chk("wen",    wen,       m_wen);
      chk("waddr",  waddr,     m_waddr);
      chk("wdata",  wdata,     m_wdata);
      chk("cpurstn", cpu_rst_n, m_starting || m_running);
      chk("start",  cpu_start, m_starting);
      chk("done",   done,      m_running);
      chk("err",    err,       m_error);
      chk("cnt",    cnt,       m_count);
   end

   // Shadow IMEM plus write / start-pulse tallies for literal checks.
   logic [DW-1:0] imem [DEPTH];
   int n_wr = 0;
   int n_starts = 0;
   always @(negedge clk) begin
      if (wen) begin
         imem[waddr] = wdata;
         n_wr++;
      end
      if (cpu_start) n_starts++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1, "watchdog");
   end

   task automatic boot_pulse();
      @(negedge clk);
      boot = 1'b1; valid = 1'b0; last = 1'b0;
      @(negedge clk);
      boot = 1'b0;
   endtask

   // Offer one word after 'gap' idle cycles; returns just after the accepting edge.
   task automatic send(input logic [DW-1:0] d, input bit l, input int gap);
      int t;
      repeat (gap) begin
         @(negedge clk);
         valid = 1'b0;
      end
      @(negedge clk);
      valid = 1'b1; data = d; last = l;
      t = 0;
      while (!ld_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (!ld_ready) begin
         n_vec++; n_bad++;
         $display("FAIL send_timeout: ready got 0 expected 1 for word 0x%0h", d);
      end
      @(posedge clk);
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      valid = 1'b0; last = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int wr0, st0, wr_at_rst;
      rst = 1'b1; boot = 1'b0; valid = 1'b0; data = '0; last = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_ready", ld_ready, 0);
      chk("rst_cpurstn", cpu_rst_n, 0);
      chk("rst_cnt", cnt, 0);
      chk("rst_waddr", waddr, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("idle_no_ready", ld_ready, 0);

      // Basic 4-word program.
      boot_pulse();
      send(32'h11, 0, 0); send(32'h22, 0, 0); send(32'h33, 0, 0); send(32'h44, 1, 0);
      idle(3);
      chk("t1_imem0", imem[0], 32'h11);
      chk("t1_imem1", imem[1], 32'h22);
      chk("t1_imem2", imem[2], 32'h33);
      chk("t1_imem3", imem[3], 32'h44);
      chk("t1_cnt", cnt, 4);
      chk("t1_starts", n_starts, 1);
      chk("t1_done", done, 1);
      $display("load 4 words: cnt=%0d starts=%0d done=%0d", cnt, n_starts, done);

      // Reload from RUN with a boot request ignored mid-load.
      boot_pulse();
      chk("t2_cpurstn_low", cpu_rst_n, 0);
      chk("t2_done_low", done, 0);
      send(32'hA0, 0, 2);
      boot_pulse();
      send(32'hA1, 1, 1);
      idle(3);
      chk("t2_imem0", imem[0], 32'hA0);
      chk("t2_imem1", imem[1], 32'hA1);
      chk("t2_cnt", cnt, 2);
      chk("t2_starts", n_starts, 2);
      $display("reload 2 words: cnt=%0d starts=%0d", cnt, n_starts);

      // Valid toggled irregularly.
      wr0 = n_wr;
      boot_pulse();
      for (int i = 0; i < 6; i++) send(32'h100 + i, i == 5, $urandom_range(0, 3));
      idle(3);
      chk("t3_writes", n_wr - wr0, 6);
      for (int i = 0; i < 6; i++) chk("t3_imem", imem[i], 32'h100 + i);
      chk("t3_cnt", cnt, 6);
      $display("gapped load 6 words: writes=%0d cnt=%0d", n_wr - wr0, cnt);

      // Overflow: 8 words, no last.
      wr0 = n_wr;
      boot_pulse();
      for (int i = 0; i < 8; i++) send(32'h200 + i, 0, 0);
      @(negedge clk);
      data = 32'h2FF;
      repeat (4) @(negedge clk);
      chk("t4_err", err, 1);
      chk("t4_cpurstn", cpu_rst_n, 0);
      chk("t4_ready", ld_ready, 0);
      chk("t4_writes", n_wr - wr0, 8);
      for (int i = 0; i < 8; i++) chk("t4_imem", imem[i], 32'h200 + i);
      $display("overflow load: err=%0d writes=%0d", err, n_wr - wr0);
      idle(0);

      // Exactly full program: last on the 8th word.
      wr0 = n_wr; st0 = n_starts;
      boot_pulse();
      chk("t5_err_clr", err, 0);
      for (int i = 0; i < 8; i++) send(32'h300 + i, i == 7, 0);
      idle(3);
      chk("t5_err", err, 0);
      chk("t5_done", done, 1);
      chk("t5_starts", n_starts - st0, 1);
      chk("t5_writes", n_wr - wr0, 8);
      chk("t5_imem7", imem[7], 32'h307);
      $display("full load: done=%0d err=%0d writes=%0d", done, err, n_wr - wr0);

      // Reset mid-load after two accepted words.
      boot_pulse();
      send(32'h400, 0, 0);
      send(32'h401, 0, 0);
      data = 32'h402;
      #1 rst = 1'b1;
      #1;
      wr_at_rst = n_wr;
      chk("t6_ready", ld_ready, 0);
      chk("t6_wen", wen, 0);
      chk("t6_waddr", waddr, 0);
      chk("t6_wdata", wdata, 0);
      chk("t6_cpurstn", cpu_rst_n, 0);
      chk("t6_start", cpu_start, 0);
      chk("t6_done", done, 0);
      chk("t6_err", err, 0);
      chk("t6_cnt", cnt, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      chk("t6_no_write", n_wr, wr_at_rst);
      chk("t6_imem0", imem[0], 32'h400);
      chk("t6_imem2", imem[2], 32'h302);
      chk("t6_idle_ready", ld_ready, 0);
      $display("reset mid-load: writes after reset=%0d", n_wr - wr_at_rst);
      idle(0);
      boot_pulse();
      send(32'h500, 1, 0);
      idle(3);
      chk("t7_imem0", imem[0], 32'h500);
      chk("t7_cnt", cnt, 1);
      chk("t7_done", done, 1);
      $display("post-reset load: cnt=%0d done=%0d", cnt, done);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
